// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collision_pkg
//  Description : Shared collision definitions: edge-code bit positions,
//                accumulator state encoding and the per-frame report record.
//  Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

    // Bit positions inside a 4-bit hit-edge code {Left, Top, Right, Bottom}
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    // Report record fields are sized for the widest supported configuration;
    // narrower instances zero-extend into them.
    localparam int REPORT_COUNT_MAX_WIDTH = 16;
    localparam int REPORT_COORD_MAX_WIDTH = 16;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } collision_state_t;

    typedef struct packed {
        logic [3:0]                        edges;
        logic [REPORT_COUNT_MAX_WIDTH-1:0] count;
        logic [REPORT_COORD_MAX_WIDTH-1:0] x;
        logic [REPORT_COORD_MAX_WIDTH-1:0] y;
    } collision_report_t;

endpackage
`default_nettype wire

// File: rtl/collision_report_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : collision_report_buffer
//  Description : Single-entry valid/ack holding register for a collision
//                report, flagging when a pending report gets replaced.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_report_buffer
    import collision_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_publish,
    input  collision_report_t i_report,
    input  logic              i_ack,
    output logic              o_valid,
    output collision_report_t o_report,
    output logic              o_overrun
);

    logic              r_valid;
    logic              r_overrun;
    collision_report_t r_report;

    // Load on publish; an ack in the same cycle counts as consuming the old one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_report  <= '0;
        end else if (i_publish) begin
            r_report  <= i_report;
            r_valid   <= 1'b1;
            r_overrun <= r_valid && !i_ack;
        end else if (i_ack && r_valid) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
    assign o_report  = r_report;

endmodule
`default_nettype wire

// File: rtl/floor_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : floor_collision_detector
//  Description : Accumulates floor/player pixel overlaps over a video frame
//                and publishes a per-frame collision report at each SOF.
//  Revision    : 1.0 - initial release
// ============================================================================
module floor_collision_detector
    import collision_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int COORD_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [COORD_WIDTH-1:0] pixelX,
    input  logic [COORD_WIDTH-1:0] pixelY,
    input  logic                   floorDrawingRequest,
    input  logic [3:0]             floorHitEdgeCode,
    input  logic                   playerDrawingRequest,
    input  logic                   collisionAck,
    output logic                   collisionValid,
    output logic [3:0]             collisionEdges,
    output logic [COUNT_WIDTH-1:0] collisionCount,
    output logic [COORD_WIDTH-1:0] firstHitX,
    output logic [COORD_WIDTH-1:0] firstHitY,
    output logic                   overrun
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = {COUNT_WIDTH{1'b1}};

    collision_state_t       r_state;
    collision_state_t       w_next_state;
    logic                   w_hit;
    logic                   w_publish;
    logic                   w_accumulating;
    logic [3:0]             r_acc_edges;
    logic [COUNT_WIDTH-1:0] r_acc_count;
    logic [COORD_WIDTH-1:0] r_acc_x;
    logic [COORD_WIDTH-1:0] r_acc_y;
    collision_report_t      w_acc_report;
    collision_report_t      w_out_report;

    assign w_hit          = floorDrawingRequest && playerDrawingRequest;
    // The SOF pixel itself belongs to the frame it opens, even the very first one
    assign w_accumulating = (r_state == ACCUM) || startOfFrame;
    assign w_publish      = (r_state == ACCUM) && startOfFrame && (r_acc_count != '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave WAIT_SOF on the first SOF, then stay in ACCUM
    always_comb begin
        w_next_state = r_state;
        if (r_state == WAIT_SOF && startOfFrame) begin
            w_next_state = ACCUM;
        end
    end

    // Per-frame accumulator; SOF restarts it, seeded by a coincident hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_edges <= '0;
            r_acc_count <= '0;
            r_acc_x     <= '0;
            r_acc_y     <= '0;
        end else if (w_accumulating) begin
            if (startOfFrame) begin
                r_acc_edges <= w_hit ? floorHitEdgeCode : 4'h0;
                r_acc_count <= w_hit ? COUNT_WIDTH'(1) : '0;
                if (w_hit) begin
                    r_acc_x <= pixelX;
                    r_acc_y <= pixelY;
                end
            end else if (w_hit) begin
                r_acc_edges <= r_acc_edges | floorHitEdgeCode;
                if (r_acc_count != c_count_max) begin
                    r_acc_count <= r_acc_count + COUNT_WIDTH'(1);
                end
                if (r_acc_count == '0) begin
                    r_acc_x <= pixelX;
                    r_acc_y <= pixelY;
                end
            end
        end
    end

    // Widen the accumulator into the shared report record
    always_comb begin
        w_acc_report       = '0;
        w_acc_report.edges = r_acc_edges;
        w_acc_report.count = REPORT_COUNT_MAX_WIDTH'(r_acc_count);
        w_acc_report.x     = REPORT_COORD_MAX_WIDTH'(r_acc_x);
        w_acc_report.y     = REPORT_COORD_MAX_WIDTH'(r_acc_y);
    end

    collision_report_buffer u_report_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_publish (w_publish),
        .i_report  (w_acc_report),
        .i_ack     (collisionAck),
        .o_valid   (collisionValid),
        .o_report  (w_out_report),
        .o_overrun (overrun)
    );

    assign collisionEdges = w_out_report.edges;
    assign collisionCount = w_out_report.count[COUNT_WIDTH-1:0];
    assign firstHitX      = w_out_report.x[COORD_WIDTH-1:0];
    assign firstHitY      = w_out_report.y[COORD_WIDTH-1:0];

    // Upper record bits are always zero for narrow configurations
    if (COUNT_WIDTH < REPORT_COUNT_MAX_WIDTH) begin : g_count_hi
        logic w_unused_count_hi;
        assign w_unused_count_hi = |w_out_report.count[REPORT_COUNT_MAX_WIDTH-1:COUNT_WIDTH];
    end

    if (COORD_WIDTH < REPORT_COORD_MAX_WIDTH) begin : g_coord_hi
        logic w_unused_coord_hi;
        assign w_unused_coord_hi = |{w_out_report.x[REPORT_COORD_MAX_WIDTH-1:COORD_WIDTH],
                                     w_out_report.y[REPORT_COORD_MAX_WIDTH-1:COORD_WIDTH]};
    end

endmodule
`default_nettype wire

// File: tb/tb_floor_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floor_collision_detector
//  Description : Self-checking bench for floor_collision_detector with a
//                behavioural frame model and an expected-report queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_collision_detector;
    import collision_pkg::*;

    localparam int COUNT_WIDTH = 8;
    localparam int COORD_WIDTH = 11;
    localparam int c_sat       = (1 << COUNT_WIDTH) - 1;

    typedef struct packed {
        logic [3:0]             edges;
        logic [COUNT_WIDTH-1:0] count;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic                   ovr;
    } exp_report_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   startOfFrame = 1'b0;
    logic [COORD_WIDTH-1:0] pixelX = '0;
    logic [COORD_WIDTH-1:0] pixelY = '0;
    logic                   floorDrawingRequest = 1'b0;
    logic [3:0]             floorHitEdgeCode = 4'h0;
    logic                   playerDrawingRequest = 1'b0;
    logic                   collisionAck = 1'b0;
    logic                   collisionValid;
    logic [3:0]             collisionEdges;
    logic [COUNT_WIDTH-1:0] collisionCount;
    logic [COORD_WIDTH-1:0] firstHitX;
    logic [COORD_WIDTH-1:0] firstHitY;
    logic                   overrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_acc;
    int          m_cnt;
    logic [3:0]  m_edges;
    int          m_x, m_y;
    bit          m_valid, m_ovr;
    exp_report_t exp_q[$];

    floor_collision_detector #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .COORD_WIDTH (COORD_WIDTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (startOfFrame),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .floorDrawingRequest  (floorDrawingRequest),
        .floorHitEdgeCode     (floorHitEdgeCode),
        .playerDrawingRequest (playerDrawingRequest),
        .collisionAck         (collisionAck),
        .collisionValid       (collisionValid),
        .collisionEdges       (collisionEdges),
        .collisionCount       (collisionCount),
        .firstHitX            (firstHitX),
        .firstHitY            (firstHitY),
        .overrun              (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_edges = 4'h0; m_x = 0; m_y = 0;
        m_valid = 0; m_ovr = 0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_valid"}, 32'(collisionValid), 32'd0);
        check_value({tag, "_edges"}, 32'(collisionEdges), 32'd0);
        check_value({tag, "_count"}, 32'(collisionCount), 32'd0);
        check_value({tag, "_x"},     32'(firstHitX),      32'd0);
        check_value({tag, "_y"},     32'(firstHitY),      32'd0);
        check_value({tag, "_ovr"},   32'(overrun),        32'd0);
    endtask

    // One pixel clock: drive, advance the model at the edge, then compare
    task automatic step(input bit sof, input bit fdr, input logic [3:0] code,
                        input bit pdr, input int x, input int y, input bit ack);
        bit          hit;
        bit          pub;
        exp_report_t e;
        @(negedge clk);
        startOfFrame         = sof;
        floorDrawingRequest  = fdr;
        floorHitEdgeCode     = code;
        playerDrawingRequest = pdr;
        pixelX               = COORD_WIDTH'(x);
        pixelY               = COORD_WIDTH'(y);
        collisionAck         = ack;
        @(posedge clk);
        hit = fdr && pdr;
        pub = m_acc && sof && (m_cnt != 0);
        if (pub) begin
            e.edges = m_edges;
            e.count = COUNT_WIDTH'(m_cnt);
            e.x     = COORD_WIDTH'(m_x);
            e.y     = COORD_WIDTH'(m_y);
            m_ovr   = m_valid && !ack;
            m_valid = 1;
            e.ovr   = m_ovr;
            exp_q.push_back(e);
        end else if (ack && m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
        if (sof) begin
            m_acc   = 1;
            m_cnt   = hit ? 1 : 0;
            m_edges = hit ? code : 4'h0;
            if (hit) begin m_x = x; m_y = y; end
        end else if (m_acc && hit) begin
            m_edges = m_edges | code;
            if (m_cnt == 0) begin m_x = x; m_y = y; end
            if (m_cnt < c_sat) m_cnt++;
        end
        #1;
        check_value("valid", 32'(collisionValid), 32'(m_valid));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_value("edges",   32'(collisionEdges), 32'(e.edges));
            check_value("count",   32'(collisionCount), 32'(e.count));
            check_value("first_x", 32'(firstHitX),      32'(e.x));
            check_value("first_y", 32'(firstHitY),      32'(e.y));
            check_value("overrun", 32'(overrun),        32'(e.ovr));
        end
    endtask

    task automatic idle(input bit ack);
        step(0, 0, 4'h0, 0, 0, 0, ack);
    endtask

    task automatic hit_at(input int x, input int y, input logic [3:0] code);
        step(0, 1, code, 1, x, y, 0);
    endtask

    task automatic sof(input bit ack);
        step(1, 0, 4'h0, 0, 0, 0, ack);
    endtask

    initial begin
        model_reset();
        // Power-on reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // Hits before the first SOF are never reported
        hit_at(10, 10, 4'hF);
        hit_at(11, 10, 4'hF);
        sof(0);
        idle(0);
        sof(0);
        idle(0);

        // Basic frame: three hits, non-overlap pixels ignored
        hit_at(100, 200, 4'(1 << EDGE_TOP));
        step(0, 1, 4'hF, 0, 300, 300, 0);
        step(0, 0, 4'hF, 1, 301, 300, 0);
        hit_at(101, 200, 4'(1 << EDGE_BOTTOM));
        hit_at(102, 200, 4'(1 << EDGE_TOP));
        idle(0);
        sof(0);
        idle(0);
        idle(1);
        idle(0);
        idle(1);

        // Saturation: 300 hits in one frame
        for (int i = 0; i < 300; i++) begin
            hit_at(i, 50, 4'(1 << EDGE_RIGHT));
        end
        sof(0);
        idle(1);

        // Hit coincident with SOF belongs to the new frame
        hit_at(9, 9, 4'(1 << EDGE_RIGHT));
        step(1, 1, 4'(1 << EDGE_LEFT), 1, 5, 7, 0);
        idle(1);
        idle(0);
        sof(0);
        idle(1);

        // Overrun, then publish coincident with ack
        hit_at(20, 21, 4'h1);
        sof(0);
        hit_at(30, 31, 4'h2);
        hit_at(32, 31, 4'h8);
        sof(0);
        hit_at(40, 41, 4'h4);
        sof(1);
        idle(0);
        idle(1);

        // Asynchronous reset mid-frame with a report pending
        hit_at(60, 61, 4'h3);
        sof(0);
        hit_at(70, 71, 4'hC);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sof(0);
        idle(0);
        sof(0);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
